quota_stream: RTL and testbench
===============================

QUOTA_STREAM -- requirements
Module: quota_stream

Interface
REQ-001: Parameter BITSTREAM, default 64, is the stream length T in beats per vector (T >= 2).
REQ-002: Parameter QUANT, default 8, is the signed input sample width Q (2 <= Q <= 16).
REQ-003: Parameter CH, default 4, is the number of parallel channels (CH >= 1).
REQ-004: Derived widths SHALL be QW = $clog2(BITSTREAM+1) for quotas and CW = $clog2(BITSTREAM) for the beat counter.
REQ-005: clk  in  1  single clock; all state on rising edge.
REQ-006: rst_n  in  1  asynchronous, active-low reset.
REQ-007: in_valid  in  1  input vector valid.
REQ-008: in_ready  out  1  block can accept a vector.
REQ-009: in_data  in  CH*Q  two's-complement samples; channel c at [c*Q +: Q].
REQ-010: in_mode  in  1  0 = thermometer, 1 = spread; sampled with in_data.
REQ-011: out_valid  out  1  beat valid.
REQ-012: out_ready  in  1  consumer accepts beat.
REQ-013: out_bits  out  CH  one stochastic bit per channel for current beat.
REQ-014: out_last  out  1  current beat is beat T-1.
REQ-015: out_quota  out  CH*QW  latched quota per channel; channel c at [c*QW +: QW].

Function
REQ-016: Quota per channel SHALL be s = ((q + 2^(Q-1))*T + 2^(Q-1)) >> Q, computed without intermediate truncation; range 0..T inclusive.
REQ-017: FSM SHALL have states IDLE and STREAM; in_ready = 1 only in IDLE; out_valid = 1 only in STREAM.
REQ-018: IDLE: in_valid && in_ready at an edge SHALL latch all quotas and in_mode, clear beat counter k and per-channel accumulators, enter STREAM.
REQ-019: First beat SHALL be valid in the cycle after acceptance (1-cycle latency); out_quota valid and stable throughout STREAM.
REQ-020: Beat k advances only on out_valid && out_ready; while stalled out_bits, out_last, out_quota SHALL hold.
REQ-021: Thermometer mode: out_bits[c] = (k < s_c).
REQ-022: Spread mode: sum = acc_c + s_c; out_bits[c] = (sum >= T); on beat handshake acc_c <= sum - (bit ? T : 0); acc_c starts at 0 (width QW+1).
REQ-023: Each channel SHALL emit exactly s_c ones over T beats in both modes; s = 0 gives all zeros, s = T all ones.
REQ-024: out_last = 1 exactly when k = T-1; handshake of that beat returns FSM to IDLE; no same-cycle new accept (throughput T+1 cycles/vector minimum).
REQ-025: in_valid, in_data, in_mode SHALL be ignored while in STREAM.

Reset
REQ-026: rst_n low SHALL immediately force IDLE, in_ready = 0, out_valid = 0, out_bits = 0, out_last = 0, out_quota = 0, k = 0, accumulators = 0.
REQ-027: in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-028: Reset asserted mid-stream SHALL abort the vector; no remaining beats are emitted after release.

Verification (T=64, Q=8, CH=4)
REQ-029: in_data {-128,0,64,127}, mode 0 -> out_quota {0,32,48,64}; ch1 ones on beats 0..31 only; ch3 all ones; ch0 all zeros; out_last only on beat 63.
REQ-030: Spread mode, q=-64 (s=16) -> ones at beats 3,7,...,63; q=64 (s=48) -> ones at beats k mod 4 in {1,2,3}; counts 16 and 48.
REQ-031: out_ready low 5 cycles at beat 10 -> outputs frozen, still exactly 64 beats, per-channel ones count unchanged.
REQ-032: rst_n pulsed low at beat 20 -> all outputs 0 same cycle; after release in_ready = 1 next edge; fresh vector streams correctly from beat 0.
REQ-033: Sweep q from -128 to 127 on all channels -> out_quota matches REQ-016 formula; in_valid toggled during STREAM never changes latched quotas.

Source files
------------

// File: rtl/quota_stream.sv
// ============================================================================
// quota_stream
// ----------------------------------------------------------------------------
// Converts a vector of CH signed QUANT-bit samples into CH parallel
// stochastic bitstreams of BITSTREAM beats each. Every channel emits exactly
// s ones over the T beats, where s is the sample rescaled to 0..T:
//
//     s = ((q + 2^(Q-1)) * T + 2^(Q-1)) >> Q
//
// Two emission orders are supported, selected per vector by in_mode_i:
//   0 = thermometer : beat k carries a one while k < s (ones first).
//   1 = spread      : an error accumulator spreads the ones evenly over the
//                     stream (first-order sigma-delta with threshold T).
//
// The block is a two-state machine. In IDLE it accepts one vector and
// latches its quotas and mode. In STREAM it presents one beat per cycle and
// advances on each out_valid_o/out_ready_i handshake. The last beat is
// flagged with out_last_o. Its handshake returns the block to IDLE, and a
// new vector can be accepted no earlier than the following cycle.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid_i   : input vector valid
//   in_ready_o   : block can accept a vector (IDLE only)
//   in_data_i    : CH two's-complement samples, channel c at [c*QUANT +: QUANT]
//   in_mode_i    : 0 = thermometer, 1 = spread; sampled with in_data_i
//   out_valid_o  : beat valid (STREAM only)
//   out_ready_i  : consumer accepts the current beat
//   out_bits_o   : one stochastic bit per channel for the current beat
//   out_last_o   : current beat is beat T-1
//   out_quota_o  : latched quota per channel, channel c at [c*QW +: QW]
//
// All outputs come straight from flops.
// ============================================================================
module quota_stream #(
    parameter  int BITSTREAM = 64,
    parameter  int QUANT     = 8,
    parameter  int CH        = 4,
    localparam int QW        = $clog2(BITSTREAM + 1),
    localparam int CW        = $clog2(BITSTREAM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [CH*QUANT-1:0] in_data_i,
    input  logic                in_mode_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CH-1:0]       out_bits_o,
    output logic                out_last_o,
    output logic [CH*QW-1:0]    out_quota_o
);

    // ------------------------------------------------------------------------
    // Local widths and constants
    // ------------------------------------------------------------------------
    // Accumulator width: acc + s stays below 2*T, which needs one bit more
    // than a quota.
    localparam int AW = QW + 1;
    // Quota product width: the offset sample is QUANT bits and T fits in QW
    // bits. One extra bit absorbs the rounding term, so nothing truncates.
    localparam int PW = QUANT + QW + 1;

    localparam logic [AW-1:0] T_A    = AW'(BITSTREAM);
    localparam logic [CW-1:0] LAST_K = CW'(BITSTREAM - 1);
    localparam logic [CW-1:0] K_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] K_ONE  = CW'(1'b1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // Rescale one signed sample to a quota in 0..T with round-half-up.
    // Flipping the sign bit is the same as adding 2^(Q-1), which gives an
    // unsigned offset in 0..2^Q-1.
    function automatic logic [QW-1:0] calc_quota(input logic [QUANT-1:0] q);
        logic [PW-1:0] off;
        logic [PW-1:0] prod;
        off  = PW'({~q[QUANT-1], q[QUANT-2:0]});
        prod = off * PW'(BITSTREAM) + (PW'(1'b1) << (QUANT - 1));
        return prod[QUANT +: QW];
    endfunction

    // Bit emitted for one channel at beat k, given the latched quota and the
    // current spread accumulator.
    function automatic logic beat_bit(input logic          mode,
                                      input logic [CW-1:0] k,
                                      input logic [QW-1:0] s,
                                      input logic [AW-1:0] acc);
        logic [AW-1:0] sum;
        logic          b;
        sum = acc + AW'(s);
        if (mode) begin
            b = (sum >= T_A);
        end else begin
            b = (AW'(k) < AW'(s));
        end
        return b;
    endfunction

    // Spread accumulator after a handshake. T is removed whenever a one was
    // emitted, so the accumulator always stays below T.
    function automatic logic [AW-1:0] acc_step(input logic [QW-1:0] s,
                                               input logic [AW-1:0] acc);
        logic [AW-1:0] sum;
        logic [AW-1:0] nxt;
        sum = acc + AW'(s);
        if (sum >= T_A) begin
            nxt = sum - T_A;
        end else begin
            nxt = sum;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    k_q,     k_d;
    logic             mode_q,  mode_d;
    logic [CH*QW-1:0] quota_q, quota_d;
    logic [CH*AW-1:0] acc_q,   acc_d;

    // Output registers
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [CH-1:0]    bits_q,  bits_d;
    logic             last_q,  last_d;

    // Handshake qualifiers
    logic accept_s;
    logic beat_hs_s;
    logic last_beat_s;

    // Decode the input and output handshakes of the current cycle.
    always_comb begin
        accept_s    = (state_q == S_IDLE)   && ready_q && in_valid_i;
        beat_hs_s   = (state_q == S_STREAM) && valid_q && out_ready_i;
        last_beat_s = beat_hs_s && (k_q == LAST_K);
    end

    // Next-state logic for the FSM, beat counter, mode, quotas and accumulators.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mode_d  = mode_q;
        quota_d = quota_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_STREAM;
                    k_d     = K_ZERO;
                    mode_d  = in_mode_i;
                    acc_d   = {(CH*AW){1'b0}};
                    for (int c = 0; c < CH; c++) begin
                        quota_d[c*QW +: QW] = calc_quota(in_data_i[c*QUANT +: QUANT]);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (last_beat_s) begin
                    // Final beat taken: clear the per-vector state and
                    // return to IDLE. The quotas stay visible.
                    state_d = S_IDLE;
                    k_d     = K_ZERO;
                    acc_d   = {(CH*AW){1'b0}};
                end else if (beat_hs_s) begin
                    k_d = k_q + K_ONE;
                    for (int c = 0; c < CH; c++) begin
                        if (mode_q) begin
                            acc_d[c*AW +: AW] = acc_step(quota_q[c*QW +: QW],
                                                         acc_q[c*AW +: AW]);
                        end else begin
                            acc_d[c*AW +: AW] = acc_q[c*AW +: AW];
                        end
                    end
                end else begin
                    // Stalled: everything holds.
                    state_d = S_STREAM;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = K_ZERO;
                acc_d   = {(CH*AW){1'b0}};
            end
        endcase
    end

    // Next values of the registered outputs, derived from the next state so
    // that each beat appears in the same cycle its state becomes current.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_STREAM);
        last_d  = (state_d == S_STREAM) && (k_d == LAST_K);
        bits_d  = {CH{1'b0}};
        for (int c = 0; c < CH; c++) begin
            if (state_d == S_STREAM) begin
                bits_d[c] = beat_bit(mode_d, k_d, quota_d[c*QW +: QW],
                                     acc_d[c*AW +: AW]);
            end else begin
                bits_d[c] = 1'b0;
            end
        end
    end

    // State and output registers, cleared asynchronously by rst_n.
    // ready_q is cleared by reset and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= K_ZERO;
            mode_q  <= 1'b0;
            quota_q <= {(CH*QW){1'b0}};
            acc_q   <= {(CH*AW){1'b0}};
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            bits_q  <= {CH{1'b0}};
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            quota_q <= quota_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            bits_q  <= bits_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_bits_o  = bits_q;
    assign out_last_o  = last_q;
    assign out_quota_o = quota_q;

endmodule

// File: tb/tb_quota_stream.sv
// ============================================================================
// tb_quota_stream
// ----------------------------------------------------------------------------
// Directed self-checking bench for quota_stream with T=64, Q=8, CH=4.
// Expected values are hand-derived from the quota formula and the two
// emission orders.
// ============================================================================
module tb_quota_stream;

    localparam int T   = 64;
    localparam int Q   = 8;
    localparam int NCH = 4;
    localparam int QW  = 7;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [NCH*Q-1:0]   in_data;
    logic               in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [NCH-1:0]     out_bits;
    logic               out_last;
    logic [NCH*QW-1:0]  out_quota;

    int total;
    int bad;

    logic [NCH-1:0]    beat_bits [0:T-1];
    logic              beat_last [0:T-1];
    logic [NCH*QW-1:0] last_quota;

    // Vectors: ch0=-128, ch1=0, ch2=64, ch3=127 (thermometer case)
    localparam logic [31:0] VEC_A   = 32'h7F40_0080;
    localparam logic [27:0] QUOTA_A = {7'd64, 7'd48, 7'd32, 7'd0};
    // ch0=-64, ch1=64, ch2=-128, ch3=127 (spread case)
    localparam logic [31:0] VEC_B   = 32'h7F80_40C0;
    localparam logic [27:0] QUOTA_B = {7'd64, 7'd0, 7'd48, 7'd16};

    quota_stream #(.BITSTREAM(T), .QUANT(Q), .CH(NCH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mode_i   (in_mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_bits_o  (out_bits),
        .out_last_o  (out_last),
        .out_quota_o (out_quota)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one vector and wait for its acceptance edge; returns at
    // posedge+1 with beat 0 on the outputs.
    task automatic send_vector(input logic [31:0] data, input logic mode, output bit ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Consume beats into beat_bits/beat_last. Optionally stalls stall_len
    // cycles at beat stall_at (counting output changes in viol) and
    // optionally drives random input traffic while streaming.
    task automatic collect(input int stall_at, input int stall_len, input bit noise,
                           output int nbeats, output int viol);
        int k;
        int cyc;
        int st;
        logic [NCH-1:0]    hb;
        logic              hl;
        logic [NCH*QW-1:0] hq;
        k = 0; cyc = 0; st = 0; viol = 0;
        hb = '0; hl = 1'b0; hq = '0;
        while (k < T && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
                in_mode  = 1'($urandom_range(0, 1));
            end
            if (out_valid && k == stall_at && st < stall_len) begin
                if (st == 0) begin
                    hb = out_bits; hl = out_last; hq = out_quota;
                end else if (out_bits !== hb || out_last !== hl || out_quota !== hq) begin
                    viol++;
                end
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    if (st > 0 && k == stall_at &&
                        (out_bits !== hb || out_last !== hl || out_quota !== hq)) begin
                        viol++;
                    end
                    beat_bits[k] = out_bits;
                    beat_last[k] = out_last;
                    if (k == T - 1) last_quota = out_quota;
                    k++;
                end
            end
        end
        in_valid = 1'b0;
        nbeats = k;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_bits !== 4'b0000 ||
            out_last !== 1'b0 || out_quota !== 28'd0) begin
            $display("FAIL reset_outputs got rdy=%b vld=%b bits=%b last=%b quota=%h want all 0",
                     in_ready, out_valid, out_bits, out_last, out_quota);
            bad++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_ready_early got=%b want=0", in_ready);
            bad++;
        end
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_ready_rise got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
            bad++;
        end
    endtask

    task automatic test_thermometer();
        bit ok;
        int nb, viol;
        logic [NCH-1:0] want;
        send_vector(VEC_A, 1'b0, ok);
        total++;
        if (!ok || out_quota !== QUOTA_A || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL thermo_accept got ok=%b quota=%h vld=%b rdy=%b want ok=1 quota=%h vld=1 rdy=0",
                     ok, out_quota, out_valid, in_ready, QUOTA_A);
            bad++;
        end
        collect(-1, 0, 1'b0, nb, viol);
        total++;
        if (nb !== T) begin
            $display("FAIL thermo_beats got=%0d want=%0d", nb, T);
            bad++;
        end
        for (int k = 0; k < nb; k++) begin
            want = {1'b1, (k < 48) ? 1'b1 : 1'b0, (k < 32) ? 1'b1 : 1'b0, 1'b0};
            total++;
            if (beat_bits[k] !== want || beat_last[k] !== (k == T - 1)) begin
                $display("FAIL thermo_beat k=%0d got bits=%b last=%b want bits=%b last=%b",
                         k, beat_bits[k], beat_last[k], want, (k == T - 1));
                bad++;
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL thermo_end got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
            bad++;
        end
    endtask

    task automatic test_spread();
        bit ok;
        int nb, viol;
        int ones [0:NCH-1];
        logic [NCH-1:0] want;
        send_vector(VEC_B, 1'b1, ok);
        total++;
        if (!ok || out_quota !== QUOTA_B) begin
            $display("FAIL spread_quota got ok=%b quota=%h want ok=1 quota=%h", ok, out_quota, QUOTA_B);
            bad++;
        end
        collect(-1, 0, 1'b0, nb, viol);
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        for (int k = 0; k < nb; k++) begin
            want = {1'b1, 1'b0, ((k % 4) != 0) ? 1'b1 : 1'b0, ((k % 4) == 3) ? 1'b1 : 1'b0};
            for (int c = 0; c < NCH; c++) ones[c] += int'(beat_bits[k][c]);
            total++;
            if (beat_bits[k] !== want || beat_last[k] !== (k == T - 1)) begin
                $display("FAIL spread_beat k=%0d got bits=%b last=%b want bits=%b last=%b",
                         k, beat_bits[k], beat_last[k], want, (k == T - 1));
                bad++;
            end
        end
        total++;
        if (nb !== T || ones[0] !== 16 || ones[1] !== 48 || ones[2] !== 0 || ones[3] !== 64) begin
            $display("FAIL spread_counts got beats=%0d ones=%0d,%0d,%0d,%0d want 64 16,48,0,64",
                     nb, ones[0], ones[1], ones[2], ones[3]);
            bad++;
        end
    endtask

    task automatic test_stall();
        bit ok;
        int nb, viol;
        int ones [0:NCH-1];
        send_vector(VEC_A, 1'b0, ok);
        collect(10, 5, 1'b0, nb, viol);
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        for (int k = 0; k < nb; k++)
            for (int c = 0; c < NCH; c++) ones[c] += int'(beat_bits[k][c]);
        total++;
        if (!ok || viol !== 0) begin
            $display("FAIL stall_frozen got ok=%b changes=%0d want ok=1 changes=0", ok, viol);
            bad++;
        end
        total++;
        if (nb !== T || ones[0] !== 0 || ones[1] !== 32 || ones[2] !== 48 || ones[3] !== 64) begin
            $display("FAIL stall_counts got beats=%0d ones=%0d,%0d,%0d,%0d want 64 0,32,48,64",
                     nb, ones[0], ones[1], ones[2], ones[3]);
            bad++;
        end
        total++;
        if (beat_bits[10] !== 4'b1110 || beat_last[T-1] !== 1'b1) begin
            $display("FAIL stall_beat10 got bits=%b last63=%b want bits=1110 last63=1",
                     beat_bits[10], beat_last[T-1]);
            bad++;
        end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        int nb, viol;
        logic [NCH-1:0] want;
        send_vector(VEC_A, 1'b0, ok);
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (!ok || out_valid !== 1'b1 || out_bits !== 4'b1110) begin
            $display("FAIL midrst_beat20 got ok=%b vld=%b bits=%b want ok=1 vld=1 bits=1110",
                     ok, out_valid, out_bits);
            bad++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_bits !== 4'b0000 ||
            out_last !== 1'b0 || out_quota !== 28'd0) begin
            $display("FAIL midrst_clear got rdy=%b vld=%b bits=%b last=%b quota=%h want all 0",
                     in_ready, out_valid, out_bits, out_last, out_quota);
            bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL midrst_release got rdy=%b vld=%b want rdy=0 vld=0", in_ready, out_valid);
            bad++;
        end
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL midrst_ready got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
            bad++;
        end
        send_vector(VEC_B, 1'b1, ok);
        collect(-1, 0, 1'b0, nb, viol);
        total++;
        if (!ok || nb !== T) begin
            $display("FAIL midrst_fresh_beats got ok=%b beats=%0d want ok=1 beats=64", ok, nb);
            bad++;
        end
        for (int k = 0; k < nb; k++) begin
            want = {1'b1, 1'b0, ((k % 4) != 0) ? 1'b1 : 1'b0, ((k % 4) == 3) ? 1'b1 : 1'b0};
            total++;
            if (beat_bits[k] !== want) begin
                $display("FAIL midrst_fresh_beat k=%0d got=%b want=%b", k, beat_bits[k], want);
                bad++;
            end
        end
    endtask

    task automatic test_sweep();
        bit ok;
        int nb, viol, s, ones;
        logic [7:0]  qb;
        logic [6:0]  sq;
        logic [27:0] expq;
        for (int q = -128; q < 128; q++) begin
            s    = ((q + 128) * T + 128) >> Q;
            qb   = q[7:0];
            sq   = s[6:0];
            expq = {4{sq}};
            send_vector({4{qb}}, q[0], ok);
            total++;
            if (!ok || out_quota !== expq) begin
                $display("FAIL sweep_quota q=%0d got ok=%b quota=%h want ok=1 quota=%h",
                         q, ok, out_quota, expq);
                bad++;
            end
            collect(-1, 0, 1'b1, nb, viol);
            ones = 0;
            for (int k = 0; k < nb; k++) ones += int'(beat_bits[k][0]);
            total++;
            if (nb !== T || last_quota !== expq || ones !== s) begin
                $display("FAIL sweep_stream q=%0d got beats=%0d quota=%h ones=%0d want 64 %h %0d",
                         q, nb, last_quota, ones, expq, s);
                bad++;
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_thermometer();
        test_spread();
        test_stall();
        test_reset_mid_stream();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
